// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU result stage.
//   - opcode constants, flag bit indices
//   - alu_entry_t: one buffered operation (opcode, result, flags)
//   - skid_state_t: occupancy state of the 2-entry skid buffer
package alu_pkg;

  localparam int ALU_WIDTH = 64;
  localparam int ALU_OPW   = 4;
  localparam int ALU_CNTW  = 16;

  localparam logic [ALU_OPW-1:0] DIV  = 4'd0;
  localparam logic [ALU_OPW-1:0] SNE  = 4'd1;
  localparam logic [ALU_OPW-1:0] SRL  = 4'd2;
  localparam logic [ALU_OPW-1:0] NOR  = 4'd3;
  localparam logic [ALU_OPW-1:0] NAND = 4'd4;
  localparam logic [ALU_OPW-1:0] SLT  = 4'd5;
  localparam logic [ALU_OPW-1:0] SUB  = 4'd6;
  localparam logic [ALU_OPW-1:0] ADD  = 4'd7;
  localparam logic [ALU_OPW-1:0] SLTU = 4'd8;

  localparam int FLAG_CARRY = 0;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_SIGN  = 3;

  typedef struct packed {
    logic [ALU_OPW-1:0]   opcode;
    logic [ALU_WIDTH-1:0] result;
    logic [3:0]           flags;
  } alu_entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/alu_skid_buf.sv
// alu_skid_buf: generic 2-entry valid/ready skid buffer, strict FIFO order.
//   clk, rst_n (sync, active-low)
//   in_valid/in_ready/in_data   : upstream handshake and payload
//   out_valid/out_ready/out_data: downstream handshake; out_data is the main register
//
// state | meaning
// EMPTY | no entries held
// ONE   | main register valid
// FULL  | main and skid registers valid, input stalled
module alu_skid_buf
  import alu_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  skid_state_t   state, state_next;
  logic [DW-1:0] main_q, skid_q;
  logic          load_main_in, load_main_skid, load_skid;
  logic          in_xfer, out_xfer;

  // Ready depends only on registered state (and reset), never on out_ready.
  assign in_ready  = rst_n && (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (in_xfer) begin
          state_next   = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          load_main_in = 1'b1;
        end else if (in_xfer) begin
          state_next = FULL;
          load_skid  = 1'b1;
        end else if (out_xfer) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          state_next     = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_next;
      if (load_main_in) main_q <= in_data;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid) skid_q <= in_data;
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered output stage after the 64-bit ALU.
// Buffers {opcode, result, flags} in a 2-entry skid buffer, counts completed
// output transfers, and optionally accumulates sticky flags.
//   clk, rst_n (sync, active-low)
//   in_valid/in_ready, in_opcode, in_result, in_carry/zero/overflow/sign
//   out_valid/out_ready, out_opcode, out_result, out_flags {sign,ovf,zero,carry}
//   op_count     : completed output transfers, wraps
//   sticky_clr   : clear sticky flags
//   sticky_flags : OR of transferred flags
// Build option: ALU_STICKY_FLAGS_EN enables the sticky register; otherwise
// sticky_flags is constant zero and sticky_clr is ignored.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int OPW   = 4,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_opcode,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_carry,
  input  logic             in_zero,
  input  logic             in_overflow,
  input  logic             in_sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OPW-1:0]   out_opcode,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic [CNTW-1:0]  op_count,
  input  logic             sticky_clr,
  output logic [3:0]       sticky_flags
);

  localparam int DW = OPW + WIDTH + 4;

  logic [3:0]      in_flags;
  logic [DW-1:0]   in_data, out_data;
  logic            out_xfer;
  logic [CNTW-1:0] op_count_q;

  always_comb begin
    in_flags             = '0;
    in_flags[FLAG_CARRY] = in_carry;
    in_flags[FLAG_ZERO]  = in_zero;
    in_flags[FLAG_OVF]   = in_overflow;
    in_flags[FLAG_SIGN]  = in_sign;
  end

  assign in_data = {in_opcode, in_result, in_flags};

  alu_skid_buf #(.DW(DW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  assign out_opcode = out_data[DW-1 -: OPW];
  assign out_result = out_data[4 +: WIDTH];
  assign out_flags  = out_data[3:0];
  assign out_xfer   = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) op_count_q <= '0;
    else if (out_xfer) op_count_q <= op_count_q + {{(CNTW-1){1'b0}}, 1'b1};
  end

  assign op_count = op_count_q;

`ifdef ALU_STICKY_FLAGS_EN
  logic [3:0] sticky_q;

  // A clear coinciding with a transfer keeps only that transfer's flags.
  always_ff @(posedge clk) begin
    if (!rst_n) sticky_q <= '0;
    else if (sticky_clr) sticky_q <= out_xfer ? out_flags : 4'b0000;
    else if (out_xfer) sticky_q <= sticky_q | out_flags;
  end

  assign sticky_flags = sticky_q;
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = sticky_clr;
  assign sticky_flags      = 4'b0000;
`endif

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered output stage placed directly downstream of the combinational 64-bit ALU. It captures the ALU `result`, the opcode that produced it, and the carry/zero/overflow/sign flags into a 2-entry skid buffer with a valid/ready handshake. This breaks the ALU's combinational path before writeback and lets the consumer stall without losing operations. It also keeps a 16-bit count of completed operations and, optionally, sticky flags.

## Interface
- `WIDTH`, 64, datapath width; must equal the ALU width.
- `OPW`, 4, opcode width.
- `CNTW`, 16, width of the completed-operation counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `in_valid`  in  1  the ALU output is valid this cycle.
- `in_ready`  out  1  the stage accepts an entry this cycle.
- `in_opcode`  in  OPW  opcode that produced `in_result`.
- `in_result`  in  WIDTH  ALU result.
- `in_carry`, `in_zero`, `in_overflow`, `in_sign`  in  1 each  ALU flags.
- `out_valid`  out  1  head entry is valid.
- `out_ready`  in  1  consumer accepts the head entry.
- `out_opcode`  out  OPW  head entry opcode.
- `out_result`  out  WIDTH  head entry result.
- `out_flags`  out  4  head entry flags, packed as {sign, overflow, zero, carry}.
- `op_count`  out  CNTW  number of completed output transfers.
- `sticky_clr`  in  1  clears the sticky flags.
- `sticky_flags`  out  4  OR-accumulated flags, in `out_flags` order.

## Operation
- Input transfer: `in_valid && in_ready`. Output transfer: `out_valid && out_ready`.
- Storage is two entries. The main register drives `out_*`; the skid register holds a second entry. Each entry holds opcode, result and 4 flags.
- FSM states:
  - EMPTY (0 entries)
  - ONE (main valid)
  - FULL (main and skid valid)
- Transitions:
  - EMPTY: input transfer → ONE, with main loaded from the input.
  - ONE, input only → FULL, with skid loaded.
  - ONE, output only → EMPTY.
  - ONE, both → ONE, with main reloaded from the input.
  - FULL, output transfer → ONE, with main loaded from skid. No input is accepted in FULL.
- Order is strictly FIFO. No entry is dropped or duplicated.
- `in_ready` is high exactly when the state is not FULL. It is decoded from registered state only, with no combinational path from `out_ready`.
- `out_valid` is high exactly when the state is not EMPTY.
- Flags and result pass through unmodified. The stage does not recompute anything.
- `op_count` increments by 1 on each output transfer and wraps from 0xFFFF to 0x0000.
- Data registers are don't-care while their entry is invalid, but are reset to 0.

## Timing
- Latency: an input transfer in cycle N gives `out_valid` in cycle N+1 when the stage was EMPTY, or when it was in ONE with a simultaneous output transfer.
- Throughput: 1 entry/cycle sustained while `out_ready` is held high.
- Reset, while `rst_n` is low at an edge:
  - state = EMPTY
  - `in_ready` = 0 for the whole time `rst_n` is low
  - `out_valid` = 0
  - `out_opcode`, `out_result`, `out_flags` = 0
  - `op_count` = 0
  - `sticky_flags` = 0
- First cycle after `rst_n` goes high: `in_ready` = 1.
- Reset asserted mid-operation discards all buffered entries immediately at that edge.
- The producer must hold `in_*` stable while `in_valid && !in_ready`. The stage must hold `out_*` stable while `out_valid && !out_ready`.

## Configuration
- `ALU_STICKY_FLAGS_EN` defined:
  - `sticky_flags` |= the head `out_flags` on each output transfer.
  - `sticky_clr` clears the register at the next edge.
  - Clear together with a same-cycle transfer: `sticky_flags` ← that transfer's flags, i.e. clear first, then OR.
- `ALU_STICKY_FLAGS_EN` undefined: `sticky_flags` is tied to 4'b0000, `sticky_clr` is ignored, and no sticky register is synthesised.

## Structure
- Shared package `alu_pkg` holds:
  - opcode constants DIV=0, SNE=1, SRL=2, NOR=3, NAND=4, SLT=5, SUB=6, ADD=7, SLTU=8
  - flag index constants FLAG_CARRY=0, FLAG_ZERO=1, FLAG_OVF=2, FLAG_SIGN=3
  - the entry struct typedef
  - the FSM state enum (EMPTY, ONE, FULL)
- One sub-module is natural: `alu_skid_buf`, the generic 2-entry valid/ready buffer parameterised on payload width. The top level adds the counter and the sticky logic.

## Test plan
- Reset then single op: push ADD, result 0x5 with flags 4'b0000, with `out_ready`=1 → `out_valid` the next cycle with `out_result`=0x5; `op_count`=1.
- Backpressure: hold `out_ready`=0 and push SUB results 1, 2, 3 → the first two are accepted and `in_ready`=0 after the 2nd. Then release → results 1, 2, 3 come out in order and `op_count`=3.
- Streaming: 100 back-to-back ops with `out_ready`=1 → 1 result/cycle, `in_ready` never drops, `op_count`=100.
- Counter wrap: preload via 65536 transfers → `op_count` returns to 0x0000.
- Sticky (macro on): transfer flags 4'b0001 then 4'b0100 → `sticky_flags`=4'b0101. Assert `sticky_clr` together with a transfer carrying 4'b0010 → `sticky_flags`=4'b0010.
- Mid-reset: FULL state, `rst_n` low for 1 cycle → `out_valid`=0 and `in_ready`=0 during reset, `in_ready`=1 after release, no stale entry is emitted.
